// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time/duty capture with stuck-input detection
module pwm_capture #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 100_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic [9:0]       duty,
    output logic             valid,
    output logic             busy,
    output logic             stuck,
    output logic             stuck_level
);

    localparam logic [CNT_W-1:0] TIMEOUT_V  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] TIMEOUT_M1 = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic sync1, sync2, s, sp;
    logic rise, timeout_hit, capture, finish;

    logic [CNT_W-1:0] per_cnt, hi_cnt;
    logic [CNT_W-1:0] num, den, rem;
    logic [9:1]       quo_hi;
    logic [3:0]       step;

    logic [CNT_W:0]   rem_sh, diff;
    logic             q_bit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            s     <= 1'b0;
            sp    <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            s     <= sync2;
            sp    <= s;
        end
    end

    assign rise = s & ~sp;
    // Fires once: the cycle the saturating period counter steps onto TIMEOUT.
    assign timeout_hit = !rise && (per_cnt == TIMEOUT_M1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(1);
        end else begin
            if (per_cnt != TIMEOUT_V)
                per_cnt <= per_cnt + CNT_W'(1);
            hi_cnt <= hi_cnt + CNT_W'(s);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        finish    = 1'b0;
        if (timeout_hit) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (rise)
                        state_nxt = MEASURE;
                end
                MEASURE: begin
                    if (rise) begin
                        state_nxt = DIVIDE;
                        capture   = 1'b1;
                    end
                end
                DIVIDE: begin
                    if (step == 4'd9) begin
                        state_nxt = MEASURE;
                        finish    = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // One restoring step; a negative difference (MSB set) means the divisor did not fit.
    assign rem_sh = {rem, 1'b0};
    assign diff   = rem_sh - {1'b0, den};
    assign q_bit  = ~diff[CNT_W];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num         <= '0;
            den         <= '0;
            rem         <= '0;
            quo_hi      <= '0;
            step        <= '0;
            period      <= '0;
            high_time   <= '0;
            duty        <= '0;
            valid       <= 1'b0;
            busy        <= 1'b0;
            stuck       <= 1'b0;
            stuck_level <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (timeout_hit) begin
                stuck       <= 1'b1;
                stuck_level <= s;
                period      <= '0;
                high_time   <= '0;
                duty        <= {10{s}};
                valid       <= 1'b1;
                busy        <= 1'b0;
            end else begin
                if (state == IDLE && rise)
                    stuck <= 1'b0;
                if (capture) begin
                    num    <= hi_cnt;
                    den    <= per_cnt;
                    rem    <= hi_cnt;
                    quo_hi <= '0;
                    step   <= '0;
                    busy   <= 1'b1;
                end
                if (state == DIVIDE) begin
                    rem  <= q_bit ? diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
                    step <= step + 4'd1;
                    if (step != 4'd9)
                        quo_hi[4'd9 - step] <= q_bit;
                end
                if (finish) begin
                    period    <= den;
                    high_time <= num;
                    duty      <= {quo_hi, q_bit};
                    valid     <= 1'b1;
                    busy      <= 1'b0;
                end
            end
        end
    end

endmodule
